// File: rtl/sub_pkg.sv
// ==== sub_pkg : shared state encoding and counter sizing for the serial subtractor (rev 1.0) ====
`default_nettype none

package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-step operation still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_subtractor.sv
// ==== digit_subtractor : combinational DIGIT-bit slice, {bout, d} = a - b - bin (rev 1.0) ====
`default_nettype none

module digit_subtractor #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] d_o,
  output logic             bout_o
);

  logic [DIGIT:0] diff_ext;

  assign diff_ext = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, bin_i};
  assign d_o      = diff_ext[DIGIT-1:0];
  assign bout_o   = diff_ext[DIGIT];

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_chain.sv
// ==== serial_subtractor_chain : digit-serial WIDTH-bit a - b - bin behind valid/ready ports (rev 1.0) ====
`default_nettype none

module serial_subtractor_chain
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int NSTEPS = WIDTH / DIGIT;
  localparam int CW     = cnt_width(NSTEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor_chain: DIGIT must divide WIDTH exactly");
  end

  state_t           state_q;
  logic             req_ready_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             bflop_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;

  logic [DIGIT-1:0] slice_d;
  logic             bflop_d;
  logic [WIDTH-1:0] acc_d;

  digit_subtractor #(.DIGIT(DIGIT)) u_slice (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .bin_i  (bflop_q),
    .d_o    (slice_d),
    .bout_o (bflop_d)
  );

  // Slices enter at the MSB end so the LSB slice lands at bit 0 after NSTEPS shifts.
  if (NSTEPS == 1) begin : g_single_step
    assign acc_d = slice_d;
  end else begin : g_multi_step
    assign acc_d = {slice_d, acc_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      bflop_q     <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            a_q         <= a;
            b_q         <= b;
            bflop_q     <= bin;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          bflop_q <= bflop_d;
          cnt_q   <= cnt_q + CW'(1);
          // Visible result registers change only here, so they hold through IDLE and RUN.
          if (cnt_q == LAST_STEP) begin
            diff_q      <= acc_d;
            borrow_q    <= bflop_d;
            zero_q      <= (acc_d == '0);
            res_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_chain.sv
// ==== tb_serial_subtractor_chain : directed and swept checks over several WIDTH/DIGIT builds (rev 1.0) ====
`default_nettype none

module tb_serial_subtractor_chain;

  localparam int NI = 6;

  logic clk;
  logic rst;

  logic [15:0] a_r         [NI];
  logic [15:0] b_r         [NI];
  logic        bin_r       [NI];
  logic        req_valid_r [NI];
  logic        res_ready_r [NI];

  wire         req_ready_w [NI];
  wire         res_valid_w [NI];
  wire  [15:0] diff_w      [NI];
  wire         borrow_w    [NI];
  wire         zero_w      [NI];

  logic [7:0]  d8 [2];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8 DIGIT=1, instance 1: WIDTH=8 DIGIT=4
  serial_subtractor_chain #(.WIDTH(8), .DIGIT(1)) u_w8_d1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_r[0]), .req_ready(req_ready_w[0]),
    .a(a_r[0][7:0]), .b(b_r[0][7:0]), .bin(bin_r[0]),
    .res_valid(res_valid_w[0]), .res_ready(res_ready_r[0]),
    .diff(d8[0]), .borrow(borrow_w[0]), .zero(zero_w[0])
  );

  serial_subtractor_chain #(.WIDTH(8), .DIGIT(4)) u_w8_d4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_r[1]), .req_ready(req_ready_w[1]),
    .a(a_r[1][7:0]), .b(b_r[1][7:0]), .bin(bin_r[1]),
    .res_valid(res_valid_w[1]), .res_ready(res_ready_r[1]),
    .diff(d8[1]), .borrow(borrow_w[1]), .zero(zero_w[1])
  );

  assign diff_w[0] = {8'h00, d8[0]};
  assign diff_w[1] = {8'h00, d8[1]};

  // Instances 2..5: WIDTH=16 with DIGIT 1, 2, 4, 16
  for (genvar j = 0; j < 4; j++) begin : g_w16
    localparam int DG = (j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? 4 : 16;
    serial_subtractor_chain #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_r[j+2]), .req_ready(req_ready_w[j+2]),
      .a(a_r[j+2]), .b(b_r[j+2]), .bin(bin_r[j+2]),
      .res_valid(res_valid_w[j+2]), .res_ready(res_ready_r[j+2]),
      .diff(diff_w[j+2]), .borrow(borrow_w[j+2]), .zero(zero_w[j+2])
    );
  end

  function automatic int nsteps_of(input int idx);
    case (idx)
      0: return 8;
      1: return 2;
      2: return 16;
      3: return 8;
      4: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One full operation: handshake, latency, result, optional DONE stall, release.
  task automatic do_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input int stall,
                       input logic [15:0] ed, input logic eb);
    int lat;
    logic ez;
    ez = (ed == 16'h0000);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready_w[idx]), 32'd1);
    a_r[idx] = av; b_r[idx] = bv; bin_r[idx] = bi;
    req_valid_r[idx] = 1'b1;
    res_ready_r[idx] = 1'b0;
    @(posedge clk); #1;
    req_valid_r[idx] = 1'b0;
    a_r[idx] = ~av; b_r[idx] = 16'($urandom); bin_r[idx] = ~bi;
    chk("req_ready_run", 32'(req_ready_w[idx]), 32'd0);
    lat = 0;
    while (!res_valid_w[idx] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(nsteps_of(idx)));
    chk("diff", 32'(diff_w[idx]), 32'(ed));
    chk("borrow", 32'(borrow_w[idx]), 32'(eb));
    chk("zero", 32'(zero_w[idx]), 32'(ez));
    repeat (stall) begin
      @(negedge clk);
      a_r[idx] = 16'($urandom); b_r[idx] = 16'($urandom);
      req_valid_r[idx] = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid_w[idx]), 32'd1);
      chk("hold_diff", 32'(diff_w[idx]), 32'(ed));
      chk("hold_borrow", 32'(borrow_w[idx]), 32'(eb));
      chk("hold_req_ready", 32'(req_ready_w[idx]), 32'd0);
    end
    @(negedge clk);
    req_valid_r[idx] = 1'b0;
    res_ready_r[idx] = 1'b1;
    @(posedge clk); #1;
    res_ready_r[idx] = 1'b0;
    chk("release_valid", 32'(res_valid_w[idx]), 32'd0);
    chk("release_ready", 32'(req_ready_w[idx]), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, rd;
    logic        rbi, rbo;
    logic [16:0] ext;
    int          idx;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int i = 0; i < NI; i++) begin
      a_r[i] = '0; b_r[i] = '0; bin_r[i] = 1'b0;
      req_valid_r[i] = 1'b0; res_ready_r[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_req_ready", 32'(req_ready_w[i]), 32'd1);
      chk("rst_res_valid", 32'(res_valid_w[i]), 32'd0);
      chk("rst_diff", 32'(diff_w[i]), 32'd0);
      chk("rst_borrow", 32'(borrow_w[i]), 32'd0);
      chk("rst_zero", 32'(zero_w[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=8 DIGIT=1, with a 5-cycle backpressure stall on the first op
    do_op(0, 16'h005A, 16'h003C, 1'b0, 5, 16'h001E, 1'b0);
    do_op(0, 16'h0080, 16'h007F, 1'b1, 0, 16'h0000, 1'b0);
    do_op(0, 16'h0000, 16'h0001, 1'b0, 0, 16'h00FF, 1'b1);
    // WIDTH=8 DIGIT=4
    do_op(1, 16'h0010, 16'h0001, 1'b0, 0, 16'h000F, 1'b0);
    do_op(1, 16'h0000, 16'h00FF, 1'b1, 2, 16'h0000, 1'b1);
    // WIDTH=16 wrap-around on every digit size
    for (int k = 2; k < NI; k++)
      do_op(k, 16'h0000, 16'hFFFF, 1'b1, 0, 16'h0000, 1'b1);

    // Asynchronous reset partway through an 8-step operation
    @(negedge clk);
    a_r[0] = 16'h005A; b_r[0] = 16'h003C; bin_r[0] = 1'b0;
    req_valid_r[0] = 1'b1;
    @(posedge clk); #1;
    req_valid_r[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_diff", 32'(diff_w[0]), 32'd0);
    chk("midrst_borrow", 32'(borrow_w[0]), 32'd0);
    chk("midrst_zero", 32'(zero_w[0]), 32'd0);
    chk("midrst_res_valid", 32'(res_valid_w[0]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready_w[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 16'h0003, 16'h0005, 1'b0, 0, 16'h00FE, 1'b1);

    // Swept random operands on the 16-bit builds with random result stalls
    for (int n = 0; n < 1000; n++) begin
      idx = 2 + (n % 4);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      if (n % 50 == 0) rb = ra;
      ext = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbi};
      rd  = ext[15:0];
      rbo = ext[16];
      do_op(idx, ra, rb, rbi, int'($urandom_range(0, 3)), rd, rbo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
